// File: rtl/uart_tx_8syncrst_if.sv
// uart_tx_8syncrst_if: byte valid/ready handshake between a producer and the UART transmitter
interface uart_tx_8syncrst_if;
  logic [7:0] D;
  logic       valid;
  logic       ready;
  modport master (output D, valid, input ready);
  modport slave (input D, valid, output ready);
endinterface

// File: rtl/uart_tx_8syncrst.sv
// uart_tx_8syncrst: 8-bit UART transmitter, start/8 data LSB first/optional parity/stop, active-low sync reset
module uart_tx_8syncrst #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_8syncrst_if.slave   bus,
  output logic                txd,
  output logic                busy,
  output logic                done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [15:0] DMAX = 16'(CLKS_PER_BIT - 1);
  state_t      state, state_n;
  logic [15:0] div, div_n;
  logic [2:0]  cnt, cnt_n;
  logic [7:0]  shift, shift_n;
  logic        par, par_n, txd_n, done_n, adv;
  assign adv = div == DMAX;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      div   <= '0;
      cnt   <= '0;
      shift <= '0;
      par   <= 1'b0;
      txd   <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      cnt   <= cnt_n;
      shift <= shift_n;
      par   <= par_n;
      txd   <= txd_n;
      done  <= done_n;
    end
  end
  always_comb begin
    state_n = state;
    div_n   = adv ? '0 : div + 16'd1;
    cnt_n   = cnt;
    shift_n = shift;
    par_n   = par;
    case (state)
      IDLE: begin
        div_n = '0;
        if (bus.valid) begin
          state_n = START;
          shift_n = bus.D;
          par_n   = ^bus.D ^ PARITY_ODD;
          cnt_n   = '0;
        end
      end
      START:  if (adv) state_n = DATA;
      DATA: if (adv) begin
        shift_n = shift >> 1;
        cnt_n   = cnt + 3'd1;
        if (cnt == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (adv) state_n = STOP;
      STOP:   if (adv) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    txd_n = state_n == START  ? 1'b0 :
            state_n == DATA   ? shift_n[0] :
            state_n == PARITY ? par_n : 1'b1;
    done_n = state == STOP && state_n == IDLE;
    bus.ready = state == IDLE;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_8syncrst.sv
// tb_uart_tx_8syncrst: self-checking bench, five transmitter configs against a frame-level bit model
module tb_uart_tx_8syncrst;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic [4:0] valid_v, ready_v, txd_v, busy_v, done_v;
  int tests = 0;
  int fails = 0;
  int cpb[5] = '{4, 4, 4, 2, 1000};
  bit pen[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  bit pod[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  always #5 clk = ~clk;
  uart_tx_8syncrst_if if0 ();
  uart_tx_8syncrst_if if1 ();
  uart_tx_8syncrst_if if2 ();
  uart_tx_8syncrst_if if3 ();
  uart_tx_8syncrst_if if4 ();
  assign if0.D = d;
  assign if1.D = d;
  assign if2.D = d;
  assign if3.D = d;
  assign if4.D = d;
  assign if0.valid = valid_v[0];
  assign if1.valid = valid_v[1];
  assign if2.valid = valid_v[2];
  assign if3.valid = valid_v[3];
  assign if4.valid = valid_v[4];
  assign ready_v = {if4.ready, if3.ready, if2.ready, if1.ready, if0.ready};
  uart_tx_8syncrst #(.CLKS_PER_BIT(4), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(if0), .txd(txd_v[0]), .busy(busy_v[0]), .done(done_v[0]));
  uart_tx_8syncrst #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
    .clk(clk), .rst(rst), .bus(if1), .txd(txd_v[1]), .busy(busy_v[1]), .done(done_v[1]));
  uart_tx_8syncrst #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
    .clk(clk), .rst(rst), .bus(if2), .txd(txd_v[2]), .busy(busy_v[2]), .done(done_v[2]));
  uart_tx_8syncrst #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u3 (
    .clk(clk), .rst(rst), .bus(if3), .txd(txd_v[3]), .busy(busy_v[3]), .done(done_v[3]));
  uart_tx_8syncrst #(.CLKS_PER_BIT(1000), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u4 (
    .clk(clk), .rst(rst), .bus(if4), .txd(txd_v[4]), .busy(busy_v[4]), .done(done_v[4]));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask
  function automatic int flen(int i);
    return (10 + int'(pen[i])) * cpb[i];
  endfunction
  function automatic logic exp_txd(int i, int k, logic [7:0] dd);
    int idx = (k - 1) / cpb[i];
    if (idx == 0) return 1'b0;
    if (idx <= 8) return dd[idx-1];
    if (idx == 9 && pen[i]) return ^dd ^ pod[i];
    return 1'b1;
  endfunction
  task automatic idle_chk(input string tag);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("%s_txd%0d", tag, i), txd_v[i], 1'b1);
      chk($sformatf("%s_ready%0d", tag, i), ready_v[i], 1'b1);
      chk($sformatf("%s_busy%0d", tag, i), busy_v[i], 1'b0);
      chk($sformatf("%s_done%0d", tag, i), done_v[i], 1'b0);
    end
  endtask
  task automatic frame(input logic [7:0] dd, input logic [4:0] m, input bit hold, input logic [7:0] nxt);
    int maxlen = 0;
    for (int i = 0; i < 5; i++) if (m[i] && flen(i) + 1 > maxlen) maxlen = flen(i) + 1;
    d = dd;
    valid_v = m;
    tick;
    valid_v = hold ? m : 5'b0;
    d = hold ? nxt : 8'($urandom);
    for (int k = 1; k <= maxlen; k++) begin
      for (int i = 0; i < 5; i++) if (m[i] && k <= flen(i) + 1) begin
        chk($sformatf("txd%0d_d%02h_k%0d", i, dd, k), txd_v[i], exp_txd(i, k, dd));
        chk($sformatf("done%0d_d%02h_k%0d", i, dd, k), done_v[i], k == flen(i) + 1);
        chk($sformatf("ready%0d_d%02h_k%0d", i, dd, k), ready_v[i], k > flen(i));
        chk($sformatf("busy%0d_d%02h_k%0d", i, dd, k), busy_v[i], k <= flen(i));
      end
      if (k == maxlen / 2 && !hold) d = 8'($urandom);
      if (k < maxlen) tick;
    end
  endtask
  initial begin
    rst = 1'b0;
    valid_v = 5'b11111;
    d = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick;
      idle_chk("rst");
    end
    rst = 1'b1;
    valid_v = 5'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      idle_chk("post_rst");
    end
    frame(8'hA5, 5'b00111, 1'b0, 8'h00);
    frame(8'h07, 5'b00111, 1'b0, 8'h00);
    frame(8'h3C, 5'b00001, 1'b1, 8'hC3);
    frame(8'hC3, 5'b00001, 1'b0, 8'h00);
    d = 8'h55;
    valid_v = 5'b00001;
    tick;
    valid_v = 5'b0;
    d = 8'($urandom);
    repeat (21) tick;
    chk("mid_bit4_txd", txd_v[0], exp_txd(0, 22, 8'h55));
    chk("mid_bit4_busy", busy_v[0], 1'b1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    chk("abort_txd", txd_v[0], 1'b1);
    chk("abort_ready", ready_v[0], 1'b1);
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_done", done_v[0], 1'b0);
    for (int c = 0; c < 45; c++) begin
      tick;
      chk($sformatf("abort_quiet_done_c%0d", c), done_v[0], 1'b0);
      chk($sformatf("abort_quiet_txd_c%0d", c), txd_v[0], 1'b1);
    end
    frame(8'h81, 5'b00001, 1'b0, 8'h00);
    frame(8'h80, 5'b11000, 1'b0, 8'h00);
    repeat (6) frame(8'($urandom), 5'b01111, 1'b0, 8'h00);
    frame(8'($urandom), 5'b11111, 1'b0, 8'h00);
    tick;
    idle_chk("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_8syncrst.md
Name: uart_tx_8syncrst

Overview:
- Byte-wide serial transmitter: accepts one 8-bit word per valid/ready handshake and serialises it onto a single line as an asynchronous frame.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Sits at the output end of the team's 8-bit register datapath and drives an external serial line; the matching receiver captures frames back into an 8-bit register.
- Single clock domain; bit timing comes from an internal divider.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; out-of-range values are a design error.
- PARITY_EN, 0, 1 inserts a parity bit between the data and the stop bit.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even (XOR of the data bits), 1 = odd (inverted XOR); ignored when PARITY_EN=0.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous active-low reset; rst=0 at a posedge resets the block.
- D  input  8  byte to send; sampled only on the accept edge.
- valid  input  1  request to send D.
- ready  output  1  block can accept a byte this cycle.
- txd  output  1  serial line, idles high; registered output.
- busy  output  1  frame in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=0 at posedge):
  - txd=1, ready=1, busy=0, done=0.
  - state=IDLE; bit counter, divider and shift register cleared.
  - Reset overrides every other input, including valid.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: valid=1 and ready=1 at a posedge.
  - D is latched into the shift register, and the parity bit is computed from D at this edge.
  - Next state is START.
  - valid while ready=0 is ignored, with no queuing.
  - Changes to D after the accept edge have no effect.
- ready is 1 only in IDLE. It drops in the cycle after the accept edge.
- Each state other than IDLE holds txd for exactly CLKS_PER_BIT cycles. The divider counts 0..CLKS_PER_BIT-1, and the state advances when it reaches CLKS_PER_BIT-1.
- Per-state txd value:
  - START: txd=0.
  - DATA: txd=shift[0]; 8 bits sent LSB first, shift right after each bit, 3-bit counter 0..7. After bit 7 the next state is PARITY if PARITY_EN=1, else STOP.
  - PARITY: txd=parity bit.
  - STOP: txd=1.
  - IDLE: txd=1.
- Latency:
  - txd goes to 0 in the first cycle after the accept edge.
  - Frame length is (10+PARITY_EN)*CLKS_PER_BIT cycles, counted from the first start-bit cycle to the last stop-bit cycle.
- Completion:
  - At the end of STOP, the next state is IDLE.
  - done=1 for exactly the first IDLE cycle after a completed frame. ready=1 and busy=0 in that same cycle.
- Back-to-back frames:
  - An accept in the done cycle is legal. The next start bit begins in the following cycle.
  - Minimum line-idle gap between frames is therefore 1 clock beyond the stop bit.
- Reset mid-frame:
  - The frame is aborted; the effects of the reset edge are as listed above.
  - done is not pulsed.
- busy = (state != IDLE). ready = (state == IDLE). Both are registered or decoded from the state register; both are glitch-free in a single clock domain.

Test Plan:
- Reset: hold rst=0 for 3 cycles with valid=1, D=8'hFF -> txd=1, ready=1, busy=0, done=0 throughout; no frame starts after rst returns to 1 until a new accept.
- Basic frame, CLKS_PER_BIT=4, PARITY_EN=0: accept D=8'hA5.
  - txd, per 4-cycle bit: 0, 1,0,1,0,0,1,0,1, 1 (40 cycles).
  - done pulses once in cycle 41 after the accept edge; ready=0 for cycles 1-40.
- Parity, CLKS_PER_BIT=4, PARITY_EN=1: D=8'hA5 -> parity bit 0 with PARITY_ODD=0 and 1 with PARITY_ODD=1; D=8'h07 -> 1 (even) and 0 (odd); frame length 44 cycles.
- Back-to-back: accept 8'h3C, hold valid=1 with D=8'hC3 -> second start bit begins exactly 2 cycles after the first frame's last stop cycle; second frame serialises C3.
  - Changing D to 8'h00 mid-frame does not alter either frame.
- Reset mid-frame: rst=0 during data bit 4 of 8'h55 -> txd=1 on the next cycle, done never pulses, and a subsequent accept of 8'h81 sends a clean full frame.
- Divider extremes: CLKS_PER_BIT=2 and CLKS_PER_BIT=1000 with D=8'h80 -> every bit width equals CLKS_PER_BIT exactly, and the MSB data bit is the last data bit (high).
